// File: rtl/alu_rr_sched_pkg.sv
// rtl/alu_rr_sched_pkg.sv - shared types and constants for the round-robin ALU scheduler
package alu_rr_sched_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [OP_W-1:0] {
    F_AND  = 3'b000,
    F_OR   = 3'b001,
    F_ADD  = 3'b010,
    F_RSVD = 3'b011,
    F_ANDN = 3'b100,
    F_ORN  = 3'b101,
    F_SUB  = 3'b110,
    F_SLT  = 3'b111
  } alu_op_t;

  // Requester index width; a single-bit id is kept even for one requester.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_rr_sched_if.sv
// rtl/alu_rr_sched_if.sv - request/response bundle between issue logic and the scheduler
interface alu_rr_sched_if #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*3-1:0]  req_f;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_y;
  logic               rsp_zero;
  logic [ID_W-1:0]    rsp_id;

  // Issue side: presents requests, consumes responses.
  modport master (
    output req_valid, req_a, req_b, req_f, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_zero, rsp_id
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, req_f, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_zero, rsp_id
  );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU (a, b, f -> y, zero)
module alu
  import alu_rr_sched_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [OP_W-1:0]   i_f,
  output logic [DATA_W-1:0] o_y,
  output logic              o_zero
);

  // Result select; the reserved code yields zero rather than flagging anything.
  always_comb begin
    o_y = '0;
    case (i_f)
      F_AND:   o_y = i_a & i_b;
      F_OR:    o_y = i_a | i_b;
      F_ADD:   o_y = i_a + i_b;
      F_ANDN:  o_y = i_a & ~i_b;
      F_ORN:   o_y = i_a | ~i_b;
      F_SUB:   o_y = i_a - i_b;
      F_SLT:   o_y = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_y = '0;
    endcase
  end

  assign o_zero = (o_y == '0);

endmodule

// File: rtl/alu_rr_sched_rr_arbiter.sv
// rtl/alu_rr_sched_rr_arbiter.sv - round-robin pick of the first request at or after the pointer
module alu_rr_sched_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  logic            w_found;
  logic [31:0]     w_pos;
  logic [NREQ-1:0] w_shift;

  // Walk the requesters from i_ptr upward with wrap; the first valid one wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    w_shift = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos   = (32'(i_ptr) + 32'(k)) % 32'(NREQ);
      w_shift = i_req >> w_pos;
      if (!w_found && w_shift[0]) begin
        w_found = 1'b1;
        o_grant = {{(NREQ-1){1'b0}}, 1'b1} << w_pos;
        o_idx   = w_pos[ID_W-1:0];
      end
    end
  end

  assign o_any = w_found;

endmodule

// File: rtl/alu_rr_sched.sv
// rtl/alu_rr_sched.sv - shares one ALU among NREQ requesters with round-robin grant
module alu_rr_sched
  import alu_rr_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int ID_W  = id_width(NREQ),
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  alu_rr_sched_if.slave    bus,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_op_count
);

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [OP_W-1:0]     r_f;
  logic [ID_W-1:0]     r_id;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_y;
  logic                r_rsp_zero;
  logic [ID_W-1:0]     r_rsp_id;
  logic                r_busy;
  logic [CNT_W-1:0]    r_op_count;

  logic [NREQ-1:0]     w_grant;
  logic [ID_W-1:0]     w_gidx;
  logic                w_any;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [DATA_W-1:0]   w_alu_y;
  logic                w_alu_zero;

  alu_rr_sched_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  // The ALU only ever sees the latched operands, never the live request bus.
  alu u_alu (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_f    (r_f),
    .o_y    (w_alu_y),
    .o_zero (w_alu_zero)
  );

  assign w_ptr_nxt = (w_gidx == ID_W'(NREQ - 1)) ? '0 : w_gidx + ID_W'(1);

  // Accept is offered only while idle, so at most one requester sees ready.
  assign bus.req_ready = (r_state == S_IDLE && w_any) ? w_grant : '0;

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_y     = r_rsp_y;
  assign bus.rsp_zero  = r_rsp_zero;
  assign bus.rsp_id    = r_rsp_id;
  assign o_busy        = r_busy;
  assign o_op_count    = r_op_count;

  // Accept -> execute -> respond; all outputs registered alongside the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_f         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_y     <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_id    <= '0;
      r_busy      <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a     <= bus.req_a[32*w_gidx +: 32];
            r_b     <= bus.req_b[32*w_gidx +: 32];
            r_f     <= bus.req_f[3*w_gidx +: 3];
            r_id    <= w_gidx;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_y     <= w_alu_y;
          r_rsp_zero  <= w_alu_zero;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + CNT_W'(1);
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb/tb_alu_rr_sched.sv - randomized self-checking bench for alu_rr_sched
module tb_alu_rr_sched;

  localparam int NREQ  = 2;
  localparam int ID_W  = 1;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int vectors = 0;
  int errors  = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  alu_rr_sched_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  alu_rr_sched #(
    .NREQ  (NREQ),
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .o_busy     (busy),
    .o_op_count (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
    case (f)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return a - b;
      3'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // One complete transaction; mask must be nonzero. Starts and ends at a negedge in IDLE.
  task automatic run_op(input logic [NREQ-1:0] mask, input logic [NREQ*32-1:0] av,
                        input logic [NREQ*32-1:0] bv, input logic [NREQ*3-1:0] fv,
                        input int stall, input bit hold, input string tag);
    int g;
    logic [31:0] ey;
    logic [NREQ-1:0] eready;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && mask[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    end
    ey = ref_alu(av[32*g +: 32], bv[32*g +: 32], fv[3*g +: 3]);
    eready = '0;
    eready[g] = 1'b1;
    m_ptr = (g + 1) % NREQ;

    bus.req_valid = mask;
    bus.req_a = av;
    bus.req_b = bv;
    bus.req_f = fv;
    bus.rsp_ready = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready !== eready || $countones(bus.req_ready) > 1) begin
      errors++;
      $display("FAIL %s grant: req_ready=%b expected %b", tag, bus.req_ready, eready);
    end

    @(negedge clk);
    if (!hold) bus.req_valid = '0;
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b1 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL %s exec: rsp_valid=%b busy=%b req_ready=%b expected 0 1 0",
               tag, bus.rsp_valid, busy, bus.req_ready);
    end

    @(negedge clk);
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== ey || bus.rsp_zero !== (ey == 32'd0) ||
          bus.rsp_id !== ID_W'(g) || busy !== 1'b1 || bus.req_ready !== '0 ||
          op_count !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL %s resp[%0d]: v=%b y=%h z=%b id=%0d busy=%b rdy=%b cnt=%0d expected 1 %h %b %0d 1 0 %0d",
                 tag, s, bus.rsp_valid, bus.rsp_y, bus.rsp_zero, bus.rsp_id, busy,
                 bus.req_ready, op_count, ey, (ey == 32'd0), g, m_cnt);
      end
    end

    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
    vectors++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== CNT_W'(m_cnt)) begin
      errors++;
      $display("FAIL %s done: rsp_valid=%b busy=%b op_count=%0d expected 0 0 %0d",
               tag, bus.rsp_valid, busy, op_count, m_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_y !== 32'd0 || bus.rsp_zero !== 1'b0 ||
        bus.rsp_id !== '0 || busy !== 1'b0 || op_count !== '0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL reset: v=%b y=%h z=%b id=%0d busy=%b cnt=%0d rdy=%b expected all zero",
               bus.rsp_valid, bus.rsp_y, bus.rsp_zero, bus.rsp_id, busy, op_count, bus.req_ready);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    m_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_add();
    run_op(2'b01, {32'd0, 32'h5}, {32'd0, 32'h3}, {3'd0, 3'b010}, 0, 1'b0, "add");
  endtask

  task automatic test_sub_slt();
    run_op(2'b10, {32'h1234ABCD, 32'd0}, {32'h1234ABCD, 32'd0}, {3'b110, 3'd0}, 0, 1'b0, "sub_eq");
    run_op(2'b01, {32'd0, 32'hFFFFFFFF}, {32'd0, 32'h1}, {3'd0, 3'b111}, 0, 1'b0, "slt");
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++)
      run_op(2'b11, {32'h10 + 32'(i), 32'h20}, {32'h1, 32'h2}, {3'b010, 3'b110}, 0, 1'b1,
             "contend");
  endtask

  task automatic test_backpressure();
    run_op(2'b11, {32'hF0F0F0F0, 32'h0FF00FF0}, {32'h0000FFFF, 32'hFFFF0000},
           {3'b100, 3'b101}, 5, 1'b0, "backpressure");
  endtask

  task automatic test_reset_mid_exec();
    run_op(2'b10, {32'h7, 32'd0}, {32'h9, 32'd0}, {3'b010, 3'd0}, 0, 1'b0, "pre_rst");
    bus.req_valid = 2'b01;
    bus.req_a = {32'd0, 32'hAAAA5555};
    bus.req_b = {32'd0, 32'h1};
    bus.req_f = {3'd0, 3'b010};
    @(negedge clk);
    bus.req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_y !== 32'd0 || bus.rsp_zero !== 1'b0 ||
        bus.rsp_id !== '0 || busy !== 1'b0 || op_count !== '0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL rst_mid: v=%b y=%h z=%b id=%0d busy=%b cnt=%0d rdy=%b expected all zero",
               bus.rsp_valid, bus.rsp_y, bus.rsp_zero, bus.rsp_id, busy, op_count, bus.req_ready);
    end
    m_ptr = 0;
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_ghost: rsp_valid=%b busy=%b expected 0 0", bus.rsp_valid, busy);
      end
    end
    bus.rsp_ready = 1'b0;
    run_op(2'b11, {32'h3, 32'h4}, {32'h3, 32'h4}, {3'b110, 3'b110}, 0, 1'b0, "post_rst");
  endtask

  task automatic test_random();
    int ops[7] = '{0, 1, 2, 4, 5, 6, 7};
    logic [NREQ-1:0]    mask;
    logic [NREQ*32-1:0] av, bv;
    logic [NREQ*3-1:0]  fv;
    for (int n = 0; n < 60; n++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int r = 0; r < NREQ; r++) begin
        av[32*r +: 32] = $urandom;
        bv[32*r +: 32] = ($urandom_range(0, 3) == 0) ? av[32*r +: 32] : $urandom;
        fv[3*r +: 3]   = 3'(ops[$urandom_range(0, 6)]);
      end
      run_op(mask, av, bv, fv, $urandom_range(0, 2), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_wrap();
    int guard = 0;
    while (m_cnt != (1 << CNT_W) - 1 && guard < 300) begin
      run_op(2'b01, {32'd0, 32'(guard)}, {32'd0, 32'h1}, {3'd0, 3'b010}, 0, 1'b0, "fill");
      guard++;
    end
    vectors++;
    if (op_count !== {CNT_W{1'b1}}) begin
      errors++;
      $display("FAIL wrap_pre: op_count=%h expected %h", op_count, {CNT_W{1'b1}});
    end
    run_op(2'b10, {32'h1, 32'd0}, {32'h1, 32'd0}, {3'b000, 3'd0}, 0, 1'b0, "wrap");
    vectors++;
    if (op_count !== '0) begin
      errors++;
      $display("FAIL wrap_post: op_count=%h expected 0", op_count);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_f = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_slt();
    test_contention();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
